// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        CORE = 1'b0,
        HOST = 1'b1
    } req_id_t;

    // Round-robin partner of a requester id.
    function automatic req_id_t other_id(input req_id_t id);
        return (id == CORE) ? HOST : CORE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_arb_select.sv
// Winner selection between core and host, with the host starvation counter.
module arb_select
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    sel_en,
    input  logic    core_req,
    input  logic    host_req,
    input  logic    core_run,
    input  req_id_t last_winner,
    output logic    grant_valid,
    output req_id_t grant_id
);

    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    // Pick the winner: core priority while running (bounded by wait_cnt), else round-robin.
    always_comb begin
        grant_valid = core_req | host_req;
        grant_id    = CORE;
        if (core_req && host_req) begin
            if (core_run) begin
                grant_id = (wait_cnt == WAIT_LIMIT) ? HOST : CORE;
            end else begin
                grant_id = other_id(last_winner);
            end
        end else if (host_req) begin
            grant_id = HOST;
        end
    end

    // Count core grants that overtook a pending host request; saturates at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (sel_en) begin
            if (!host_req || grant_id == HOST) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core data path and the host loader.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_run,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    req_id_t           winner_q;
    req_id_t           last_winner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              grant_valid;
    req_id_t           grant_id;

    arb_select #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arb_select (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_en      (state == IDLE),
        .core_req    (core_req),
        .host_req    (host_req),
        .core_run    (core_run),
        .last_winner (last_winner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fixed IDLE -> ACCESS -> RESP sequence per transaction.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's payload in IDLE; capture read data and round-robin history in RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            winner_q     <= CORE;
            last_winner  <= HOST;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                winner_q <= grant_id;
                if (grant_id == HOST) begin
                    we_q    <= host_we;
                    addr_q  <= host_addr;
                    wdata_q <= host_wdata;
                end else begin
                    we_q    <= core_we;
                    addr_q  <= core_addr;
                    wdata_q <= core_wdata;
                end
            end
            if (state == RESP) begin
                last_winner <= winner_q;
                if (winner_q == HOST) begin
                    host_rdata_q <= mem_rdata;
                end else begin
                    core_rdata_q <= mem_rdata;
                end
            end
        end
    end

    // Decode memory strobes and acks from state; the winner's rdata is bypassed from
    // mem_rdata during RESP so it is valid alongside the ack, then held by its register.
    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        core_ack   = 1'b0;
        host_ack   = 1'b0;
        core_rdata = core_rdata_q;
        host_rdata = host_rdata_q;
        busy       = (state != IDLE);
        unique case (state)
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                if (winner_q == HOST) begin
                    host_ack   = 1'b1;
                    host_rdata = mem_rdata;
                end else begin
                    core_ack   = 1'b1;
                    core_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a synchronous memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              core_run, core_req, core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_ack;
    logic [DATA_W-1:0] core_rdata;
    logic              host_req, host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              busy;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_run   (core_run),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    // Memory model: preset contents are addr ^ 8'h5A; read data one cycle after mem_en.
    logic [7:0] mem [256];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         who;       // 0 core, 1 host
        bit         chk_data;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          last_ack_cyc = -1;
    bit          spacing_chk = 1'b0;
    int unsigned mwe_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        last_ack_cyc = -1;
    endtask

    task automatic push(input bit who, input bit chk_data, input logic [7:0] data);
        exp_t e;
        e.who = who; e.chk_data = chk_data; e.data = data;
        exp_q.push_back(e);
    endtask

    // Count acks at negedges; optionally release each requester on its own ack.
    task automatic run_acks(input int n, input bit drop_core, input bit drop_host, input int budget);
        int seen = 0;
        for (int k = 0; k < budget && seen < n; k++) begin
            @(negedge clk);
            if (core_ack || host_ack) seen++;
            if (core_ack && drop_core) core_req = 1'b0;
            if (host_ack && drop_host) host_req = 1'b0;
        end
        core_req = 1'b0;
        host_req = 1'b0;
        chk("ack_count_within_budget", 32'(seen), 32'(n));
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_ack(input bit host, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            got = host ? host_ack : core_ack;
        end
        chk(host ? "host_ack_seen" : "core_ack_seen", 32'(got), 32'd1);
    endtask

    task automatic monitor();
        exp_t e;
        bit   who;
        forever begin
            @(negedge clk);
            if (mem_we) mwe_cnt++;
            if (rst_n && (core_ack || host_ack)) begin
                if (core_ack && host_ack) begin
                    n_vec++; n_err++;
                    $display("FAIL both_acks: core_ack=1 host_ack=1, expected at most one");
                end
                who = host_ack;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_ack: core_ack=%0b host_ack=%0b, expected none", core_ack, host_ack);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_winner", 32'(who), 32'(e.who));
                    if (e.chk_data) chk(who ? "host_rdata" : "core_rdata",
                                        32'(who ? host_rdata : core_rdata), 32'(e.data));
                end
                if (spacing_chk && last_ack_cyc >= 0)
                    chk("ack_spacing", 32'(cyc - last_ack_cyc), 32'd3);
                last_ack_cyc = cyc;
            end
        end
    endtask

    task automatic main_seq();
        int t0;
        core_run = 1'b0;

        // Reset state, then reset during ACCESS of a core read of 0x10.
        do_reset();
        @(negedge clk);
        chk("reset_outputs", {core_ack, host_ack, mem_en, mem_we, mem_addr, mem_wdata, busy},
            32'd0);
        chk("reset_rdata", {core_rdata, host_rdata}, 32'd0);
        tick();
        core_run = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
        tick();
        chk("access_busy_en_addr", {busy, mem_en, mem_addr}, {2'b11, 8'h10});
        rst_n = 1'b0;
        core_req = 1'b0;
        tick();
        @(negedge clk);
        chk("reset_mid_access", {core_ack, mem_en, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Host write 0x3C to 0x05 then back-to-back host read of 0x05.
        core_run = 1'b0;
        do_reset();
        mwe_cnt = 0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 8'h3C;
        t0 = cyc;
        push(1'b1, 1'b0, 8'h00);
        wait_ack(1'b1, 10);
        chk("host_write_latency", 32'(cyc - t0), 32'd2);
        host_we = 1'b0; host_wdata = 8'hFF;
        t0 = cyc;
        push(1'b1, 1'b1, 8'h3C);
        wait_ack(1'b1, 10);
        chk("host_read_after_ack_spacing", 32'(cyc - t0), 32'd3);
        host_req = 1'b0;
        drain(5);
        repeat (3) tick();
        chk("mem_we_cycles", 32'(mwe_cnt), 32'd1);

        // core_run=1, both requesting: four core grants, then the host is forced.
        core_run = 1'b1;
        do_reset();
        spacing_chk = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h30;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
        for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 8'h6A);
        push(1'b1, 1'b1, 8'h1A);
        push(1'b0, 1'b1, 8'h6A);
        run_acks(6, 1'b0, 1'b0, 40);
        drain(5);
        spacing_chk = 1'b0;

        // core_run=0, both requesting: round-robin starting with the core.
        core_run = 1'b0;
        do_reset();
        spacing_chk = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h30;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
        push(1'b0, 1'b1, 8'h6A);
        push(1'b1, 1'b1, 8'h1A);
        push(1'b0, 1'b1, 8'h6A);
        push(1'b1, 1'b1, 8'h1A);
        run_acks(4, 1'b0, 1'b0, 30);
        drain(5);

        // Core write 0x11 @0x20 against host read @0x20 while running: core first.
        core_run = 1'b1;
        do_reset();
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h11;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        push(1'b0, 1'b0, 8'h00);
        push(1'b1, 1'b1, 8'h11);
        run_acks(2, 1'b1, 1'b1, 20);
        drain(5);

        // Core req held through its ack with a new address is a second transaction.
        do_reset();
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20;
        push(1'b0, 1'b1, 8'h11);
        push(1'b0, 1'b1, 8'h7B);
        wait_ack(1'b0, 10);
        core_addr = 8'h21;
        wait_ack(1'b0, 10);
        core_req = 1'b0;
        drain(5);
        repeat (4) tick();
        chk("idle_after_release", {busy, core_ack, host_ack}, 32'd0);
        spacing_chk = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        core_run = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        fork
            main_seq();
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached, expected completion");
                $fatal(1);
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the processor core's data path and the host loader.
- The host loader writes matrix operands before a run and reads results after end_op.
- Serialises single-beat read/write transactions through a fixed 3-cycle access sequence.
- Arbitration is core-priority while the core is running, with a starvation guard for the host, and round-robin otherwise.

Parameters:
- ADDR_W, 8, data memory address width.
- DATA_W, 8, data word width.
- MAX_WAIT, 4, number of consecutive core grants a pending host request tolerates before the host is forced.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- core_run  in  1  high while the core is executing (deasserts when end_op pulses)
- core_req  in  1  core transaction request, held until core_ack
- core_we  in  1  core write (1) / read (0)
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_ack  out  1  one-cycle completion pulse to core
- core_rdata  out  DATA_W  read data, valid with core_ack
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host request, same rules as core
- host_ack  out  1  one-cycle completion pulse to host
- host_rdata  out  DATA_W  read data, valid with host_ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous read data, valid the cycle after mem_en
- busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (rst_n low at a clock edge, including mid-transaction):
  - state goes to IDLE.
  - All outputs 0; rdata registers 0.
  - last_winner set to HOST, so the core wins the first round-robin tie.
  - wait_cnt set to 0.
  - Any in-flight transaction is dropped with no ack.
- IDLE: request inputs sampled each cycle.
  - No request: stay in IDLE.
  - Otherwise select a winner and latch its we/addr/wdata into the mem_* registers; mem_en=1 and mem_we=we in the next cycle; go to ACCESS.
- Winner selection (only one requester active: that one wins):
  - Both requesting, core_run=1, wait_cnt<MAX_WAIT: core wins.
  - Both requesting, core_run=1, wait_cnt==MAX_WAIT: host wins.
  - Both requesting, core_run=0: the requester that is not last_winner wins (round-robin).
- ACCESS: mem_en/mem_we/mem_addr/mem_wdata are driven for exactly this one cycle; go to RESP.
- RESP:
  - mem_en=0, mem_we=0.
  - Winner's ack=1 for this cycle only; its rdata register captures mem_rdata (writes also capture it; the value is don't-care).
  - The loser's ack and rdata are unchanged.
  - last_winner updated; go to IDLE.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when the core is granted while host_req=1.
  - Clears when the host is granted or host_req=0 in IDLE.
- Timing and handshake:
  - Latency is a request seen in IDLE at cycle t, ack at t+2; throughput is one transaction per 3 cycles.
  - core_ack and host_ack are never high in the same cycle.
  - Requesters hold req and payload stable until ack. A req still high in the cycle after ack counts as a new request.
  - Request inputs are ignored in ACCESS and RESP; payload changes during ACCESS/RESP have no effect.
- Writes complete at the ACCESS edge. A read that follows a write to the same address returns the new data.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - requester id constants CORE=1'b0, HOST=1'b1;
  - default ADDR_W/DATA_W.
- Optional sub-module arb_select: combinational winner selection plus the wait_cnt register. Everything else stays in one module.

Test Plan:
- Reset mid-ACCESS with core read of addr 0x10 pending -> no core_ack, next cycle state IDLE, mem_en=0, busy=0.
- Host write 0x3C to 0x05 at t, then host read 0x05 -> host_ack at t+2; read returns host_rdata=0x3C with host_ack; mem_we high only in the write's ACCESS cycle.
- core_run=1, both requesting continuously, MAX_WAIT=4 -> grant order core,core,core,core,host,core..., with acks every 3 cycles.
- core_run=0, both requesting continuously after reset -> grants alternate core,host,core,host.
- Simultaneous core write 0x11 @0x20 and host read @0x20, core_run=1 -> core wins first; host_rdata=0x11 three cycles later.
- core_req held high after ack with a new addr 0x21 -> treated as a new transaction; exactly one ack per 3-cycle window, never both acks in one cycle.
